// File: rtl/shift_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : shift_issue_stage
// Purpose  : RV32I shift decode/issue stage feeding the barrel shifter through
//            a 2-entry registered skid buffer. Optional strict funct7 checking
//            is enabled by defining SHIFT_STRICT_DECODE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module shift_issue_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_instr,
    input  logic [N-1:0] in_rs1_val,
    input  logic [N-1:0] in_rs2_val,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_a,
    output logic [4:0]   out_shamt,
    output logic [1:0]   out_type,
    output logic [4:0]   out_rd,
    output logic         out_regwrite,
    output logic         out_illegal
);

    localparam logic [6:0] c_op_reg   = 7'b0110011;
    localparam logic [6:0] c_op_imm   = 7'b0010011;
    localparam logic [2:0] c_f3_sll   = 3'b001;
    localparam logic [2:0] c_f3_sr    = 3'b101;
    localparam int         c_pw       = N + 14;

    logic            w_is_reg;
    logic            w_is_imm;
    logic            w_is_sll;
    logic            w_is_sr;
    logic            w_is_shift;
    logic [1:0]      w_type;
    logic [4:0]      w_shamt;
    logic            w_illegal;
    logic            w_regwrite;
    logic [c_pw-1:0] w_new;
    logic            w_accept;
    logic            w_out_free;
    logic            w_unused;

    logic [c_pw-1:0] r_out;
    logic            r_out_valid;
    logic [c_pw-1:0] r_skid;
    logic            r_skid_valid;

    always_comb begin
        w_is_reg   = (in_instr[6:0] == c_op_reg);
        w_is_imm   = (in_instr[6:0] == c_op_imm);
        w_is_sll   = (in_instr[14:12] == c_f3_sll);
        w_is_sr    = (in_instr[14:12] == c_f3_sr);
        w_is_shift = (w_is_reg | w_is_imm) & (w_is_sll | w_is_sr);
        w_type     = w_is_sll ? 2'b01 : (in_instr[30] ? 2'b10 : 2'b00);
        w_shamt    = w_is_reg ? in_rs2_val[4:0] : in_instr[24:20];
`ifdef SHIFT_STRICT_DECODE_EN
        // Only SRA/SRAI may carry 0100000; everything else needs all-zero funct7.
        if (w_is_sr && in_instr[30])
            w_illegal = (in_instr[31:25] != 7'b0100000);
        else
            w_illegal = (in_instr[31:25] != 7'b0000000);
`else
        w_illegal  = 1'b0;
`endif
        w_regwrite = (in_instr[11:7] != 5'd0) & ~w_illegal;
        w_new      = {in_rs1_val, w_shamt, w_type, in_instr[11:7], w_regwrite, w_illegal};
    end

    assign w_unused   = &{1'b0, in_rs2_val[N-1:5], in_instr[31], in_instr[29:25]};

    assign in_ready   = ~r_skid_valid & ~rst;
    // Non-shift beats still handshake (in_ready honoured) but never enter the buffer.
    assign w_accept   = in_valid & in_ready & ~flush & w_is_shift;
    assign w_out_free = ~r_out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // in_ready was low, so no new beat competes with the skid entry.
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out        <= w_new;
                r_out_valid  <= 1'b1;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_new;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_a        = r_out[c_pw-1 -: N];
    assign out_shamt    = r_out[13:9];
    assign out_type     = r_out[8:7];
    assign out_rd       = r_out[6:2];
    assign out_regwrite = r_out[1];
    assign out_illegal  = r_out[0];

endmodule
`default_nettype wire

// File: tb/tb_shift_issue_stage.sv
`default_nettype none
// Scoreboard bench for shift_issue_stage: directed scenarios then random traffic,
// checked against a queue-based model of a 2-deep in-order buffer.
module tb_shift_issue_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_rs1_val, in_rs2_val, out_a;
    logic [4:0]  out_shamt, out_rd;
    logic [1:0]  out_type;
    logic        out_regwrite, out_illegal;

    int n_checks = 0;
    int n_fails  = 0;
    logic [45:0] sb[$];

    always #5 clk = ~clk;

    shift_issue_stage #(.N(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_shamt(out_shamt), .out_type(out_type),
        .out_rd(out_rd), .out_regwrite(out_regwrite), .out_illegal(out_illegal)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: field-level RV32I shift semantics, packed {a,shamt,type,rd,wr,ill}.
    function automatic void ref_model(input logic [31:0] ins, input logic [31:0] rs1,
                                      input logic [31:0] rs2, output bit sh,
                                      output logic [45:0] exp);
        int op  = int'(ins[6:0]);
        int f3  = int'(ins[14:12]);
        int f7  = int'(ins[31:25]);
        int rd  = int'(ins[11:7]);
        int amt, typ, want_f7;
        bit ill, wr;
        sh  = (op == 'h33 || op == 'h13) && (f3 == 1 || f3 == 5);
        amt = (op == 'h33) ? int'(rs2 % 32) : int'((ins >> 20) % 32);
        typ = (f3 == 1) ? 1 : (ins[30] ? 2 : 0);
`ifdef SHIFT_STRICT_DECODE_EN
        want_f7 = (typ == 2) ? 32 : 0;
        ill = (f7 != want_f7);
`else
        want_f7 = f7;
        ill = 1'b0;
`endif
        wr  = (rd != 0) && !ill;
        exp = {rs1, amt[4:0], typ[1:0], rd[4:0], wr, ill};
    endfunction

    // Drive one cycle; inputs change just after posedge, acceptance resolved mid-cycle.
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] r1,
                        input logic [31:0] r2, input bit ordy, input bit fl, input bit rs);
        bit sh;
        logic [45:0] e;
        rst = rs; flush = fl; in_valid = v; in_instr = ins;
        in_rs1_val = r1; in_rs2_val = r2; out_ready = ordy;
        @(negedge clk);
        #1;
        if (rst || flush) begin
            sb.delete();
        end else if (in_valid && in_ready) begin
            ref_model(in_instr, in_rs1_val, in_rs2_val, sh, e);
            if (sh) sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: occupancy-derived handshake checks and in-order payload comparison.
    always @(negedge clk) begin
        chk("in_ready", {63'd0, in_ready}, {63'd0, (!rst && sb.size() < 2)});
        chk("out_valid", {63'd0, out_valid}, {63'd0, (sb.size() > 0)});
        if (out_valid === 1'b1 && sb.size() > 0) begin
            chk("payload", {18'd0, out_a, out_shamt, out_type, out_rd, out_regwrite, out_illegal},
                {18'd0, sb[0]});
            if (out_ready && !flush && !rst) void'(sb.pop_front());
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins = $urandom;
        case ($urandom % 4)
            0: ins[6:0] = 7'b0110011;
            1: ins[6:0] = 7'b0010011;
            2: ins[6:0] = 7'b0110011 ^ 7'(1 << ($urandom % 7));
            default: ;
        endcase
        if ($urandom % 4 != 0) ins[14:12] = ($urandom % 2) ? 3'b001 : 3'b101;
        case ($urandom % 4)
            0: ins[31:25] = 7'b0000000;
            1: ins[31:25] = 7'b0100000;
            default: ;
        endcase
        if ($urandom % 8 == 0) ins[11:7] = 5'd0;
        return ins;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        in_rs1_val = '0; in_rs2_val = '0; out_ready = 1'b0;
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("reset_outputs", {18'd0, out_a, out_shamt, out_type, out_rd, out_regwrite, out_illegal}, 64'd0);

        // SLLI x5,x6,3 then SRA x7,x8,x9
        step(1, 32'h00331293, 32'h00000001, 32'h0, 1, 0, 0);
        step(1, 32'h409453B3, 32'h80000000, 32'hFFFFFFE4, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("sra_shamt_direct", {59'd0, out_shamt}, 64'd4);

        // Backpressure: hold, fill skid, third offer refused, then drain in order
        step(1, 32'h00331293, 32'h11111111, 0, 0, 0, 0);
        step(1, 32'h00535313, 32'h22222222, 0, 0, 0, 0);
        step(1, 32'h40235393, 32'h33333333, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        // ADD is consumed and dropped
        step(1, 32'h003100B3, 32'h5, 32'h6, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        // Fill both entries, then flush with a shift offered
        step(1, 32'h00331293, 32'hAAAA0001, 0, 0, 0, 0);
        step(1, 32'h409453B3, 32'hAAAA0002, 32'h3, 0, 0, 0);
        step(1, 32'h00331293, 32'hAAAA0003, 0, 1, 1, 0);
        step(1, 32'h00331293, 32'hBBBB0004, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        // rd=x0 and non-zero funct7 on SLLI
        step(1, 32'h00331013, 32'h7, 0, 1, 0, 0);
        step(1, 32'h02331293, 32'h8, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, rand_instr(), $urandom, $urandom,
                 ($urandom % 4) != 0, ($urandom % 40) == 0, ($urandom % 250) == 0);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Execute-side issue stage sitting directly upstream of the n-bit barrel shifter.
- Decodes RV32I shift instructions (SLL/SRL/SRA/SLLI/SRLI/SRAI), selects the shift amount from rs2 or the immediate, and produces the shifter's a/shamt/type operands plus writeback tags.
- Output is a registered 2-entry skid buffer with valid/ready handshake and pipeline flush.
- Non-shift instructions are consumed and discarded.

Parameters:
- n, 32, operand data width; equals rs1/rs2 value width and out_a width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush (branch mispredict/trap).
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_instr  in  32  raw instruction word.
- in_rs1_val  in  n  rs1 register value.
- in_rs2_val  in  n  rs2 register value.
- out_valid  out  1  shifter operands valid.
- out_ready  in  1  downstream accepts the beat.
- out_a  out  n  value to shift (rs1).
- out_shamt  out  5  shift amount.
- out_type  out  2  00=SRL, 10=SRA, 01=SLL; 11 never driven while out_valid=1.
- out_rd  out  5  destination register.
- out_regwrite  out  1  writeback enable.
- out_illegal  out  1  malformed-encoding flag (see Optional Feature).

Behaviour:
- Clocking and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - out_valid=0, out_a=0, out_shamt=0, out_type=00, out_rd=0, out_regwrite=0, out_illegal=0; skid entry invalid.
  - in_ready=0 while rst=1, and 1 in the first cycle after reset.
- Decode (combinational on in_instr):
  - opcode 0110011, funct3 001 -> SLL; funct3 101 -> SRL if instr[30]=0, SRA if instr[30]=1. shamt = in_rs2_val[4:0].
  - opcode 0010011: same funct3/instr[30] mapping (SLLI/SRLI/SRAI). shamt = instr[24:20].
  - All other encodings are non-shift.
- Writeback tags: out_rd = instr[11:7]. out_regwrite = 1 unless rd=0 or out_illegal=1.
- Handshake:
  - A beat transfers when valid and ready are both 1 on the same edge.
  - in_ready = ~skid_valid & ~rst.
  - A non-shift beat is accepted (in_ready honoured) and dropped; it produces no output beat.
- Latency and throughput: 1 cycle from input acceptance to out_valid for a shift beat; full throughput of 1 beat/cycle while out_ready=1.
- Output register and skid entry:
  - Output register empty, or draining this cycle: the accepted beat loads the output register.
  - Output register held (out_valid=1, out_ready=0): the accepted beat loads the skid entry, and in_ready drops to 0 the next cycle.
  - When the output register drains and the skid entry is valid, the skid entry moves into the output register and the skid entry clears.
- Ordering: beats are strictly in order; none lost or duplicated.
- Output stability: while out_valid=1 and out_ready=0, all out_* hold their values.
- Flush:
  - Next cycle: out_valid=0 and the skid entry is cleared.
  - Any beat offered in the flush cycle is discarded, even if in_ready=1.
  - flush overrides acceptance and draining.
  - in_ready=1 the cycle after the flush.
- rst overrides flush. Reset mid-operation drops all beats.

Optional Feature:
- Macro: SHIFT_STRICT_DECODE_EN.
- Defined:
  - Required encodings: funct7 must be exactly 0000000 (SLL/SRL/SLLI/SRLI) or 0100000 (SRA/SRAI).
  - Any other funct7 with a shift funct3/opcode is still emitted, with out_illegal=1 and out_regwrite=0.
- Undefined:
  - Only instr[30] is examined; other funct7 bits are ignored.
  - out_illegal is tied 0.

Test Plan:
- Reset, then SLLI x5,x6,3 (0x00331293), rs1=0x00000001 -> next cycle out_valid=1, a=0x00000001, shamt=3, type=01, rd=5, regwrite=1.
- SRA x7,x8,x9 (0x409453B3), rs1=0x80000000, rs2=0xFFFFFFE4 -> a=0x80000000, shamt=4, type=10, rd=7.
- out_ready=0, two back-to-back shifts -> first held stable, second in skid, in_ready=0 on the third cycle; raise out_ready -> both delivered in order on consecutive cycles, then in_ready=1.
- ADD x1,x2,x3 (0x003100B3) with in_valid=1 -> in_ready=1, out_valid stays 0.
- Both entries full, flush=1 with a new shift offered -> next cycle out_valid=0, in_ready=1; offered beat never appears.
- SLLI x0,x6,3 (0x00331013) -> regwrite=0. With SHIFT_STRICT_DECODE_EN, 0x02331293 -> out_illegal=1, regwrite=0; without the macro -> illegal=0, type=01, regwrite=1.
